// File: rtl/bkm_slot_bus_if_pkg.sv
// Shared constants and types for the BKM option-slot bus slave: command bytes,
// slot identity bytes and the bus-phase FSM state encoding.
package bkm_slot_bus_if_pkg;

    localparam logic [7:0] CMD_IRQ    = 8'h02;
    localparam logic [7:0] CMD_ID     = 8'h20;
    localparam logic [7:0] CMD_VIDEO  = 8'h21;
    localparam logic [7:0] CMD_PREP   = 8'h22;
    localparam logic [7:0] CMD_SERIAL = 8'h23;
    localparam logic [7:0] CMD_BLIP1  = 8'h30;
    localparam logic [7:0] CMD_BLIP2  = 8'h40;
    localparam logic [7:0] BYTE_SEL   = 8'hFF;

    // Sub-commands accepted while in the interrupt-control phase
    localparam logic [7:0] IRQ_ON     = 8'h01;
    localparam logic [7:0] IRQ_OFF    = 8'h00;

    localparam logic [7:0] SLOT_ID_DEFAULT = 8'h88;
    localparam logic [7:0] SLOT_ID_62HS    = 8'h82;

    localparam logic [7:0] BUS_IDLE_BYTE   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IRQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_SKIP = 3'd4
    } bus_state_e;

endpackage

// File: rtl/bkm_slot_bus_if_if.sv
// Slot-side pin bundle of the BKM monitor bus. The slave modport is the option
// card view; the master modport is the monitor view.
interface bkm_slot_bus_if_if;

    logic       slot_x;
    logic       clk_rw;
    logic       ax_d;
    logic       r_wx;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe_x;
    logic       int_x;
    logic       int_oe_x;

    modport slave (
        input  slot_x, clk_rw, ax_d, r_wx, data_in,
        output data_out, data_oe_x, int_x, int_oe_x
    );

    modport master (
        output slot_x, clk_rw, ax_d, r_wx, data_in,
        input  data_out, data_oe_x, int_x, int_oe_x
    );

endinterface

// File: rtl/bkm_slot_bus_if_sync.sv
// Brings the asynchronous monitor control pins into the board clock domain and
// turns the rising edge of the synchronised clk_rw into a single-cycle strobe.
module bkm_slot_bus_if_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clkRw_i,
    input  logic axD_i,
    input  logic rWx_i,
    input  logic slotX_i,
    output logic axD_o,
    output logic rWx_o,
    output logic slotX_o,
    output logic strobe_o
);

    // Bit order inside a stage: {slot_x, r_wx, ax_d, clk_rw}
    logic [3:0] stage_q [SYNC_STAGES];
    logic       clkRwPrev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= 4'b1000;
            end
            clkRwPrev_q <= 1'b0;
        end else begin
            stage_q[0] <= {slotX_i, rWx_i, axD_i, clkRw_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            clkRwPrev_q <= stage_q[SYNC_STAGES-1][0];
        end
    end

    assign strobe_o = stage_q[SYNC_STAGES-1][0] & ~clkRwPrev_q;
    assign axD_o    = stage_q[SYNC_STAGES-1][1];
    assign rWx_o    = stage_q[SYNC_STAGES-1][2];
    assign slotX_o  = stage_q[SYNC_STAGES-1][3];

endmodule

// File: rtl/bkm_slot_bus_if.sv
// BKM option-slot bus slave: decodes monitor command/address/data bytes, serves
// ID, serial and a writable prepare bank with busy-status emulation, drives int_x.
module bkm_slot_bus_if
    import bkm_slot_bus_if_pkg::*;
#(
    parameter logic [7:0]              SLOT_ID     = SLOT_ID_DEFAULT,
    parameter int                      SERIAL_LEN  = 7,
    parameter logic [8*SERIAL_LEN-1:0] SERIAL_INIT = "2000555",
    parameter int                      REG_AW      = 8,
    parameter logic [7:0]              STAT_ADDR   = 8'h27,
    parameter int                      BUSY_READS  = 9,
    parameter int                      SYNC_STAGES = 2
) (
    input  logic              clk_20mhz,
    input  logic              reset_x,
    bkm_slot_bus_if_if.slave  bus,
    input  logic              irq_req,
    output logic              wr_stb,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int                DEPTH     = 2**REG_AW;
    localparam int                CW        = $clog2(BUSY_READS + 1);
    localparam logic [CW-1:0]     BUSY_LOAD = CW'(BUSY_READS);
    localparam logic [REG_AW-1:0] STAT_IDX  = STAT_ADDR[REG_AW-1:0];

    // Bank addressing is taken from the low bits of the bus byte, so the
    // address width cannot exceed one byte.
    if (SYNC_STAGES < 2 || REG_AW < 1 || REG_AW > 8 || BUSY_READS < 1) begin : g_bad_params
        $error("bkm_slot_bus_if: unsupported parameter set");
    end

    logic axS, rWxS, slotXS, strobe;

    bkm_slot_bus_if_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_20mhz),
        .rst_ni  (reset_x),
        .clkRw_i (bus.clk_rw),
        .axD_i   (bus.ax_d),
        .rWx_i   (bus.r_wx),
        .slotX_i (bus.slot_x),
        .axD_o   (axS),
        .rWx_o   (rWxS),
        .slotX_o (slotXS),
        .strobe_o(strobe)
    );

    bus_state_e        state_q;
    logic              selected_q;
    logic              irqEn_q;
    logic              dataOe_q;
    logic              intX_q;
    logic [7:0]        cmd_q;
    logic [7:0]        addr_q;
    logic [7:0]        outData_q;
    logic [CW-1:0]     busyCnt_q;
    logic [7:0]        bank_q [DEPTH];
    logic              pend_q;
    logic              axStb_q;
    logic              rWxStb_q;
    logic              slotStb_q;
    logic              wrStb_q;
    logic [REG_AW-1:0] wrAddr_q;
    logic [7:0]        wrData_q;

    logic [7:0]        busByte;
    logic [REG_AW-1:0] newIdx;
    logic [REG_AW-1:0] curIdx;
    logic              busyNow;
    logic [7:0]        serialByte;
    logic [7:0]        rdVal;

    assign busByte = bus.data_in;
    assign newIdx  = busByte[REG_AW-1:0];
    assign curIdx  = addr_q[REG_AW-1:0];
    assign busyNow = (busyCnt_q != '0);

    // Control pins are frozen at the strobe; the data byte itself is consumed
    // one cycle later, giving data_in a full extra board clock to settle.
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) begin
            pend_q    <= 1'b0;
            axStb_q   <= 1'b0;
            rWxStb_q  <= 1'b0;
            slotStb_q <= 1'b0;
        end else begin
            pend_q <= strobe;
            if (strobe) begin
                axStb_q   <= axS;
                rWxStb_q  <= rWxS;
                slotStb_q <= slotXS;
            end
        end
    end

    // Serial byte 0 sits in the most significant byte of the string literal
    always_comb begin
        serialByte = 8'h00;
        for (int i = 0; i < SERIAL_LEN; i++) begin
            if (busByte == 8'(i)) begin
                serialByte = SERIAL_INIT[8*(SERIAL_LEN-1-i) +: 8];
            end
        end
    end

    // Value to present for a read of the address byte currently on the bus
    always_comb begin
        rdVal = 8'hFF;
        case (cmd_q)
            CMD_ID:     rdVal = (busByte == 8'h00) ? SLOT_ID : 8'h00;
            CMD_SERIAL: rdVal = serialByte;
            CMD_PREP: begin
                if (newIdx == STAT_IDX) begin
                    rdVal = busyNow ? bank_q[STAT_IDX] : 8'h00;
                end else begin
                    rdVal = bank_q[newIdx];
                end
            end
            default:    rdVal = 8'hFF;
        endcase
    end

    // Bus-phase FSM, prepare bank, busy counter and registered board outputs.
    // Status reads are retired on the data phase so an address-only access
    // never consumes a busy count.
    always_ff @(posedge clk_20mhz or negedge reset_x) begin
        if (!reset_x) begin
            state_q    <= ST_IDLE;
            selected_q <= 1'b0;
            irqEn_q    <= 1'b0;
            dataOe_q   <= 1'b0;
            outData_q  <= BUS_IDLE_BYTE;
            cmd_q      <= 8'h00;
            addr_q     <= 8'h00;
            busyCnt_q  <= '0;
            wrStb_q    <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= 8'h00;
            intX_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else begin
            wrStb_q <= 1'b0;
            intX_q  <= irqEn_q & irq_req;
            if (pend_q) begin
                if (slotStb_q) begin
                    state_q    <= ST_IDLE;
                    selected_q <= 1'b0;
                    dataOe_q   <= 1'b0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (busByte == BYTE_SEL) begin
                                selected_q <= ~selected_q;
                                dataOe_q   <= 1'b0;
                            end else if (busByte == CMD_IRQ) begin
                                state_q    <= ST_IRQ;
                                selected_q <= 1'b1;
                                dataOe_q   <= 1'b1;
                            end else if (selected_q) begin
                                if (busByte == CMD_BLIP1 || busByte == CMD_BLIP2) begin
                                    state_q <= ST_SKIP;
                                end else begin
                                    cmd_q    <= busByte;
                                    state_q  <= ST_ADDR;
                                    dataOe_q <= 1'b1;
                                end
                            end
                        end
                        ST_SKIP: state_q <= ST_IDLE;
                        ST_IRQ: begin
                            if (busByte == IRQ_ON) begin
                                irqEn_q <= 1'b1;
                            end else if (busByte == IRQ_OFF) begin
                                irqEn_q <= 1'b0;
                            end else if (busByte == BYTE_SEL) begin
                                state_q  <= ST_IDLE;
                                dataOe_q <= 1'b0;
                                if (!irqEn_q) begin
                                    selected_q <= 1'b0;
                                end
                            end
                        end
                        ST_ADDR: begin
                            if (!axStb_q) begin
                                addr_q    <= busByte;
                                outData_q <= rdVal;
                                state_q   <= ST_DATA;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                        ST_DATA: begin
                            if (!axStb_q) begin
                                addr_q    <= busByte;
                                outData_q <= rdVal;
                            end else begin
                                state_q <= ST_IDLE;
                                if (cmd_q == CMD_PREP) begin
                                    if (!rWxStb_q) begin
                                        bank_q[curIdx] <= busByte;
                                        wrStb_q        <= 1'b1;
                                        wrAddr_q       <= curIdx;
                                        wrData_q       <= busByte;
                                        if (curIdx == STAT_IDX) begin
                                            busyCnt_q <= BUSY_LOAD;
                                        end
                                    end else if (curIdx == STAT_IDX) begin
                                        if (busyNow) begin
                                            busyCnt_q <= busyCnt_q - CW'(1);
                                        end else begin
                                            bank_q[STAT_IDX] <= 8'h00;
                                        end
                                    end
                                end
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.data_out  = (state_q == ST_DATA && rWxS) ? outData_q : BUS_IDLE_BYTE;
    assign bus.data_oe_x = ~(dataOe_q & rWxS & axS);
    assign bus.int_oe_x  = irqEn_q;
    assign bus.int_x     = intX_q;

    assign wr_stb  = wrStb_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;

endmodule

// File: tb/tb_bkm_slot_bus_if.sv
// Directed bench for bkm_slot_bus_if: drives monitor bus cycles byte by byte and
// compares read data, pad enables, interrupt pins and board write strobes.
module tb_bkm_slot_bus_if;

    logic       clk     = 1'b0;
    logic       resetX  = 1'b0;
    logic       irqReq  = 1'b0;
    logic       wrStb;
    logic [7:0] wrAddr;
    logic [7:0] wrData;

    int         checks   = 0;
    int         errors   = 0;
    int         stbCount = 0;
    logic [7:0] lastWrAddr = 8'h00;
    logic [7:0] lastWrData = 8'h00;

    bkm_slot_bus_if_if bus ();

    bkm_slot_bus_if dut (
        .clk_20mhz(clk),
        .reset_x  (resetX),
        .bus      (bus.slave),
        .irq_req  (irqReq),
        .wr_stb   (wrStb),
        .wr_addr  (wrAddr),
        .wr_data  (wrData)
    );

    always #25 clk = ~clk;

    always @(negedge clk) begin
        if (wrStb === 1'b1) begin
            stbCount++;
            lastWrAddr = wrAddr;
            lastWrData = wrData;
        end
    end

    // One monitor byte: set phase pins, let them synchronise, then pulse clk_rw
    task automatic busCycle(input logic axd, input logic rw, input logic [7:0] val);
        @(negedge clk);
        bus.ax_d    = axd;
        bus.r_wx    = rw;
        bus.data_in = val;
        repeat (4) @(negedge clk);
        bus.clk_rw = 1'b1;
        repeat (6) @(negedge clk);
        bus.clk_rw = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic busRead(output logic [7:0] dout, output logic oex);
        @(negedge clk);
        bus.ax_d    = 1'b1;
        bus.r_wx    = 1'b1;
        bus.data_in = 8'h00;
        repeat (4) @(negedge clk);
        dout = bus.data_out;
        oex  = bus.data_oe_x;
        bus.clk_rw = 1'b1;
        repeat (6) @(negedge clk);
        bus.clk_rw = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic readAt(input logic [7:0] cmd, input logic [7:0] addr,
                          output logic [7:0] dout, output logic oex);
        busCycle(1'b0, 1'b0, cmd);
        busCycle(1'b0, 1'b0, addr);
        busRead(dout, oex);
    endtask

    task automatic test_reset();
        resetX = 1'b0;
        repeat (4) @(negedge clk);
        resetX = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("[TB] FAIL reset_data_out got %h want %h", bus.data_out, 8'hFF); end
        checks++; if (bus.data_oe_x !== 1'b1) begin errors++; $display("[TB] FAIL reset_data_oe_x got %b want 1", bus.data_oe_x); end
        checks++; if (bus.int_x !== 1'b0) begin errors++; $display("[TB] FAIL reset_int_x got %b want 0", bus.int_x); end
        checks++; if (bus.int_oe_x !== 1'b0) begin errors++; $display("[TB] FAIL reset_int_oe_x got %b want 0", bus.int_oe_x); end
        checks++; if (wrStb !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_stb got %b want 0", wrStb); end
    endtask

    task automatic test_id_read();
        logic [7:0] d;
        logic       oe;
        busCycle(1'b0, 1'b0, 8'hFF);
        readAt(8'h20, 8'h00, d, oe);
        checks++; if (d !== 8'h88) begin errors++; $display("[TB] FAIL id_data got %h want %h", d, 8'h88); end
        checks++; if (oe !== 1'b0) begin errors++; $display("[TB] FAIL id_oe_x got %b want 0", oe); end
        checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("[TB] FAIL id_after_read got %h want %h", bus.data_out, 8'hFF); end
        busCycle(1'b0, 1'b0, 8'hFF);
    endtask

    task automatic test_serial();
        logic [7:0] d;
        logic       oe;
        busCycle(1'b0, 1'b0, 8'hFF);
        readAt(8'h23, 8'h03, d, oe);
        checks++; if (d !== 8'h30) begin errors++; $display("[TB] FAIL serial3 got %h want %h", d, 8'h30); end
        checks++; if (oe !== 1'b0) begin errors++; $display("[TB] FAIL serial3_oe_x got %b want 0", oe); end
        readAt(8'h23, 8'h07, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL serial7 got %h want %h", d, 8'h00); end
        readAt(8'h23, 8'h00, d, oe);
        checks++; if (d !== 8'h32) begin errors++; $display("[TB] FAIL serial0 got %h want %h", d, 8'h32); end
        readAt(8'h23, 8'h06, d, oe);
        checks++; if (d !== 8'h35) begin errors++; $display("[TB] FAIL serial6 got %h want %h", d, 8'h35); end
        readAt(8'h21, 8'h00, d, oe);
        checks++; if (d !== 8'hFF) begin errors++; $display("[TB] FAIL video_cmd got %h want %h", d, 8'hFF); end
        busCycle(1'b0, 1'b0, 8'hFF);
        @(negedge clk);
        bus.ax_d = 1'b1;
        bus.r_wx = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.data_oe_x !== 1'b1) begin errors++; $display("[TB] FAIL deselect_oe_x got %b want 1", bus.data_oe_x); end
    endtask

    task automatic test_prep_write();
        logic [7:0] d;
        logic       oe;
        int         base;
        busCycle(1'b0, 1'b0, 8'hFF);
        base = stbCount;
        busCycle(1'b0, 1'b0, 8'h22);
        busCycle(1'b0, 1'b0, 8'h25);
        busCycle(1'b1, 1'b0, 8'hA0);
        checks++; if (stbCount - base !== 1) begin errors++; $display("[TB] FAIL wr_stb_count got %0d want 1", stbCount - base); end
        checks++; if (lastWrAddr !== 8'h25) begin errors++; $display("[TB] FAIL wr_addr got %h want %h", lastWrAddr, 8'h25); end
        checks++; if (lastWrData !== 8'hA0) begin errors++; $display("[TB] FAIL wr_data got %h want %h", lastWrData, 8'hA0); end
        readAt(8'h22, 8'h25, d, oe);
        checks++; if (d !== 8'hA0) begin errors++; $display("[TB] FAIL prep_read got %h want %h", d, 8'hA0); end
        busCycle(1'b0, 1'b0, 8'h22);
        busCycle(1'b0, 1'b0, 8'h00);
        busCycle(1'b0, 1'b0, 8'h25);
        busRead(d, oe);
        checks++; if (d !== 8'hA0) begin errors++; $display("[TB] FAIL readdress got %h want %h", d, 8'hA0); end
        // Blip commands must swallow the next byte, so the FF must not deselect
        busCycle(1'b0, 1'b0, 8'h30);
        busCycle(1'b0, 1'b0, 8'hFF);
        readAt(8'h22, 8'h25, d, oe);
        checks++; if (d !== 8'hA0) begin errors++; $display("[TB] FAIL blip30 got %h want %h", d, 8'hA0); end
        busCycle(1'b0, 1'b0, 8'h40);
        busCycle(1'b0, 1'b0, 8'hFF);
        readAt(8'h22, 8'h25, d, oe);
        checks++; if (d !== 8'hA0) begin errors++; $display("[TB] FAIL blip40 got %h want %h", d, 8'hA0); end
    endtask

    task automatic test_status();
        logic [7:0] d;
        logic       oe;
        busCycle(1'b0, 1'b0, 8'h22);
        busCycle(1'b0, 1'b0, 8'h27);
        busCycle(1'b1, 1'b0, 8'h09);
        for (int i = 0; i < 9; i++) begin
            readAt(8'h22, 8'h27, d, oe);
            checks++; if (d !== 8'h09) begin errors++; $display("[TB] FAIL busy_read%0d got %h want %h", i, d, 8'h09); end
        end
        readAt(8'h22, 8'h27, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL status_done got %h want %h", d, 8'h00); end
        busCycle(1'b0, 1'b0, 8'h22);
        busCycle(1'b0, 1'b0, 8'h27);
        busCycle(1'b1, 1'b0, 8'h09);
        for (int i = 0; i < 3; i++) begin
            readAt(8'h22, 8'h27, d, oe);
            checks++; if (d !== 8'h09) begin errors++; $display("[TB] FAIL pre_reload%0d got %h want %h", i, d, 8'h09); end
        end
        busCycle(1'b0, 1'b0, 8'h22);
        busCycle(1'b0, 1'b0, 8'h27);
        busCycle(1'b1, 1'b0, 8'h03);
        checks++; if (lastWrData !== 8'h03) begin errors++; $display("[TB] FAIL reload_wr_data got %h want %h", lastWrData, 8'h03); end
        for (int i = 0; i < 9; i++) begin
            readAt(8'h22, 8'h27, d, oe);
            checks++; if (d !== 8'h03) begin errors++; $display("[TB] FAIL reload_read%0d got %h want %h", i, d, 8'h03); end
        end
        readAt(8'h22, 8'h27, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reload_done got %h want %h", d, 8'h00); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        logic       oe;
        busCycle(1'b0, 1'b0, 8'h02);
        busCycle(1'b0, 1'b0, 8'h01);
        busCycle(1'b0, 1'b0, 8'hFF);
        checks++; if (bus.int_oe_x !== 1'b1) begin errors++; $display("[TB] FAIL irq_oe_on got %b want 1", bus.int_oe_x); end
        checks++; if (bus.int_x !== 1'b0) begin errors++; $display("[TB] FAIL irq_idle got %b want 0", bus.int_x); end
        irqReq = 1'b1;
        #1;
        checks++; if (bus.int_x !== 1'b0) begin errors++; $display("[TB] FAIL irq_latency got %b want 0", bus.int_x); end
        @(negedge clk);
        checks++; if (bus.int_x !== 1'b1) begin errors++; $display("[TB] FAIL irq_asserted got %b want 1", bus.int_x); end
        // Interrupts enabled: the closing FF keeps the slot selected
        readAt(8'h20, 8'h00, d, oe);
        checks++; if (d !== 8'h88) begin errors++; $display("[TB] FAIL irq_keep_sel got %h want %h", d, 8'h88); end
        irqReq = 1'b0;
        busCycle(1'b0, 1'b0, 8'h02);
        busCycle(1'b0, 1'b0, 8'h00);
        busCycle(1'b0, 1'b0, 8'hFF);
        checks++; if (bus.int_oe_x !== 1'b0) begin errors++; $display("[TB] FAIL irq_oe_off got %b want 0", bus.int_oe_x); end
        checks++; if (bus.int_x !== 1'b0) begin errors++; $display("[TB] FAIL irq_off got %b want 0", bus.int_x); end
        readAt(8'h20, 8'h00, d, oe);
        checks++; if (d !== 8'hFF) begin errors++; $display("[TB] FAIL irq_deselect got %h want %h", d, 8'hFF); end
        checks++; if (oe !== 1'b1) begin errors++; $display("[TB] FAIL irq_deselect_oe got %b want 1", oe); end
    endtask

    task automatic test_slot_x();
        logic [7:0] d;
        logic       oe;
        int         base;
        busCycle(1'b0, 1'b0, 8'hFF);
        busCycle(1'b0, 1'b0, 8'h22);
        base = stbCount;
        bus.slot_x = 1'b1;
        busCycle(1'b0, 1'b0, 8'h25);
        bus.slot_x = 1'b0;
        busCycle(1'b1, 1'b0, 8'h77);
        checks++; if (stbCount - base !== 0) begin errors++; $display("[TB] FAIL slot_x_stb got %0d want 0", stbCount - base); end
        readAt(8'h22, 8'h25, d, oe);
        checks++; if (d !== 8'hFF) begin errors++; $display("[TB] FAIL slot_x_deselect got %h want %h", d, 8'hFF); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic       oe;
        int         base;
        busCycle(1'b0, 1'b0, 8'h02);
        busCycle(1'b0, 1'b0, 8'h01);
        busCycle(1'b0, 1'b0, 8'hFF);
        busCycle(1'b0, 1'b0, 8'h22);
        busCycle(1'b0, 1'b0, 8'h30);
        base = stbCount;
        @(negedge clk);
        resetX = 1'b0;
        #1;
        checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("[TB] FAIL mid_data_out got %h want %h", bus.data_out, 8'hFF); end
        checks++; if (bus.data_oe_x !== 1'b1) begin errors++; $display("[TB] FAIL mid_oe_x got %b want 1", bus.data_oe_x); end
        checks++; if (bus.int_oe_x !== 1'b0) begin errors++; $display("[TB] FAIL mid_int_oe_x got %b want 0", bus.int_oe_x); end
        repeat (3) @(negedge clk);
        resetX = 1'b1;
        busCycle(1'b1, 1'b0, 8'hA5);
        checks++; if (stbCount - base !== 0) begin errors++; $display("[TB] FAIL mid_stb got %0d want 0", stbCount - base); end
        busCycle(1'b0, 1'b0, 8'hFF);
        readAt(8'h22, 8'h30, d, oe);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL mid_bank got %h want %h", d, 8'h00); end
    endtask

    initial begin
        bus.slot_x  = 1'b0;
        bus.clk_rw  = 1'b0;
        bus.ax_d    = 1'b0;
        bus.r_wx    = 1'b0;
        bus.data_in = 8'h00;
        $display("[TB] start");
        test_reset();
        test_id_read();
        test_serial();
        test_prep_write();
        test_status();
        test_irq();
        test_slot_x();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
